// File: rtl/cp0_reg_file.sv
// MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_EN to build the Count/Compare timer and its TI interrupt.
module cp0_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic [4:0]  read_addr,
    output logic [31:0] read_data,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic        exc_en,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic        exc_badvaddr_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        int_pending
);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic [31:0] badvaddr_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;

    logic        ti;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic [31:0] timer_wval;

    // An MTC0 only lands when no exception or ERET commits in the same cycle.
    logic wr_ok;
    assign wr_ok = write_en & ~exc_en & ~eret;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        phase_q;
    logic        ti_q;
    logic [31:0] count_inc;
    logic        count_wr;
    logic        compare_wr;

    assign count_inc  = count_q + 32'd1;
    assign count_wr   = wr_ok && (write_addr == A_COUNT);
    assign compare_wr = wr_ok && (write_addr == A_COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            phase_q   <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (count_wr) begin
                count_q <= write_data;
                phase_q <= 1'b0;
            end else if (phase_q) begin
                count_q <= count_inc;
            end
            if (compare_wr)
                compare_q <= write_data;
            if (compare_wr)
                ti_q <= 1'b0;
            else if (phase_q && !count_wr && (count_inc == compare_q))
                ti_q <= 1'b1;
        end
    end

    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
    assign timer_wval = write_data;
`else
    assign ti         = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
    assign timer_wval = '0;
`endif

    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] status_wr;
    logic [31:0] cause_wr;

    assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti, 14'd0, ip_hw_q[5] | ti, ip_hw_q[4:0],
                         ip_sw_q, 1'b0, exc_code_q, 2'b00};
    assign status_wr  = {9'd0, 1'b1, 6'd0, write_data[15:8], 6'd0,
                         write_data[1:0]};
    assign cause_wr   = {cause_val[31:10], write_data[9:8], cause_val[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
        end else begin
            ip_hw_q <= hw_int;
            if (exc_en) begin
                // A nested exception keeps the original return point.
                if (!exl_q) begin
                    epc_q <= exc_delay_slot ? exc_pc - 32'd4 : exc_pc;
                    bd_q  <= exc_delay_slot;
                end
                exl_q      <= 1'b1;
                exc_code_q <= exc_code;
                if (exc_badvaddr_valid)
                    badvaddr_q <= exc_badvaddr;
            end else if (eret) begin
                exl_q <= 1'b0;
            end else if (write_en) begin
                unique case (write_addr)
                    A_STATUS: begin
                        im_q  <= write_data[15:8];
                        exl_q <= write_data[1];
                        ie_q  <= write_data[0];
                    end
                    A_CAUSE: ip_sw_q <= write_data[9:8];
                    A_EPC:   epc_q   <= write_data;
                    default: ;
                endcase
            end
        end
    end

    logic byp;
    assign byp = wr_ok && (write_addr == read_addr);

    always_comb begin
        read_data = '0;
        if (read_en) begin
            unique case (read_addr)
                A_BADVADDR: read_data = badvaddr_q;
                A_COUNT:    read_data = byp ? timer_wval : count_rd;
                A_COMPARE:  read_data = byp ? timer_wval : compare_rd;
                A_STATUS:   read_data = byp ? status_wr : status_val;
                A_CAUSE:    read_data = byp ? cause_wr : cause_val;
                A_EPC:      read_data = byp ? write_data : epc_q;
                default:    read_data = '0;
            endcase
        end
    end

    assign status      = status_val;
    assign cause       = cause_val;
    assign epc         = epc_q;
    assign int_pending = ie_q & ~exl_q & |(cause_val[15:8] & im_q);

endmodule

// File: doc/cp0_reg_file.md
# cp0_reg_file

Coprocessor-0 register file for the MIPS pipeline. It sits directly downstream of ID-stage register-address generation and consumes its `cp_read_en`/`cp_read_addr` (MFC0) and `cp_write_en`/`cp_write_addr` (MTC0) outputs. It holds the privileged state: BadVAddr, Count, Compare, Status, Cause and EPC. It takes exception and ERET commits from the MEM/WB side and raises a level interrupt request back to the pipeline.

## Interface
- No parameters.
- `clk` in 1 — single system clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `read_en` in 1 — MFC0 read strobe, from `cp_read_en`.
- `read_addr` in 5 — CP0 register number, from `cp_read_addr`.
- `read_data` out 32 — read result; 0 when `read_en`=0.
- `write_en` in 1 — MTC0 commit strobe.
- `write_addr` in 5 — CP0 register number.
- `write_data` in 32 — MTC0 source value.
- `exc_en` in 1 — exception commit, one-cycle pulse.
- `exc_code` in 5 — ExcCode for Cause[6:2].
- `exc_pc` in 32 — PC of the faulting instruction.
- `exc_delay_slot` in 1 — faulting instruction is in a delay slot.
- `exc_badvaddr_valid` in 1 — load BadVAddr on this exception.
- `exc_badvaddr` in 32 — faulting address.
- `eret` in 1 — ERET commit, one-cycle pulse.
- `hw_int` in 6 — external interrupt lines, level.
- `status` out 32, `cause` out 32, `epc` out 32 — live register values.
- `int_pending` out 1 — interrupt request to the pipeline.

## Operation
- Implemented registers:
  - 8 BadVAddr: read-only to MTC0.
  - 9 Count.
  - 11 Compare.
  - 12 Status.
  - 13 Cause.
  - 14 EPC.
- Any other address reads 0; MTC0 to it is ignored.
- Status fields:
  - BEV[22]: read-only 1.
  - IM[15:8], EXL[1], IE[0]: writable.
  - All other bits read 0.
- Cause fields:
  - BD[31]: hardware only.
  - TI[30]: hardware only.
  - IP[15:10]: sampled from `hw_int`; IP[15] = `hw_int[5]` OR TI.
  - IP[9:8]: MTC0-writable.
  - ExcCode[6:2]: hardware only.
  - All other bits 0.
- Read path is combinational. Same-cycle MTC0 to the same address bypasses: `read_data` shows the masked value that will be written.
- Exception (`exc_en`=1):
  - If EXL was 0: EPC = `exc_pc` − 4 when `exc_delay_slot`, else `exc_pc`. BD = `exc_delay_slot`.
  - If EXL was 1: EPC and BD are unchanged.
  - Always: EXL ← 1, ExcCode ← `exc_code`.
  - BadVAddr ← `exc_badvaddr` only when `exc_badvaddr_valid`.
- ERET: EXL ← 0.
- Priority, highest first: `exc_en` > `eret` > `write_en`. A lower-priority event in the same cycle is dropped entirely, including an MTC0 to an unrelated register.
- `int_pending` = IE & ~EXL & |(Cause[15:8] & Status[15:8]). It is combinational from registered state.

## Timing
- Reset values:
  - Status = 0x0040_0000.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Tick phase = 0.
  - `int_pending` = 0.
  - `read_data` = 0.
- Reset asserted mid-operation clears all state immediately. It is not clock-qualified.
- MTC0 and exception updates take effect at the next rising edge. The `status`/`cause`/`epc` outputs change in the cycle after the commit.
- `hw_int` is registered into Cause.IP[15:10] every cycle. An edge on `hw_int` is visible on `int_pending` 1 cycle later.
- Count increments by 1 every second cycle (1-bit phase toggle). It wraps 0xFFFF_FFFF → 0 with no side effect.
- MTC0 to Count loads `write_data`, overrides that cycle's increment, and resets the phase to 0.
- TI is set at the edge where Count increments to a value equal to Compare. Reset (0 == 0) does not set TI.
- MTC0 to Compare clears TI in the same edge. If the same edge would also set TI, the clear wins.

## Configuration
- Macro: `CP0_TIMER_EN`.
- Defined:
  - Count, Compare, the phase toggle and TI are implemented as above.
  - TI ORs into IP[15].
- Undefined:
  - Count and Compare read 0 and ignore writes.
  - TI is constant 0; IP[15] = `hw_int[5]` only.
  - No timer flops are synthesized.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → Status reads 0x0040_0000, all other CP0 registers read 0, `int_pending`=0.
- **MTC0/MFC0 bypass:** write Status = 0xFFFF_FFFF with a same-cycle read of 12 → `read_data` = 0x0040_FF03 in that cycle; the next cycle `status` = 0x0040_FF03.
- **Delay-slot exception:** `exc_en`, code 0x04, `exc_pc` 0xBFC0_0100, delay slot, badvaddr valid 0x0000_0003 → EPC 0xBFC0_00FC, BD=1, ExcCode 4, EXL=1, BadVAddr 3.
- **Nested exception and ERET:**
  - A second exception with EXL=1 and `exc_pc` 0x8000_0000 → EPC and BD unchanged, ExcCode updated.
  - ERET then clears EXL.
  - ERET coincident with `exc_en` → EXL stays 1.
- **Timer (`CP0_TIMER_EN`):**
  - Compare=5, Count=0, Status=0x0000_8001 → TI rises when Count reaches 5 (10 cycles after the Count write); `int_pending` follows on the next read.
  - MTC0 Compare clears TI.
- **Hardware interrupt:** Status=0x0000_0401, pulse `hw_int[0]` → `int_pending` high 1 cycle later and held while the line is high. With EXL=1 → `int_pending` stays 0.
